// File: rtl/sti_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sti_sched_pkg
//  Description : Shared types for the STI_DAC load scheduler. Holds the
//                sequencer state encoding, the queued request entry layout
//                and the helper that converts a length code to a bit count.
//  Revision    : 1.0  initial release
// ============================================================================
package sti_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } sched_state_t;

    typedef struct packed {
        logic        last;
        logic        low;
        logic        msb;
        logic        fill;
        logic [1:0]  length;
        logic [15:0] data;
    } sched_entry_t;

    localparam logic [5:0] BIT_CNT_MAX = 6'd63;

    // Length code 00/01/10/11 -> 8/16/24/32 expected serial bits.
    function automatic logic [5:0] LEN_BITS(input logic [1:0] length);
        return {({1'b0, length} + 3'd1), 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sti_sched_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sti_sched_fifo
//  Description : DEPTH-entry synchronous FIFO of scheduler request entries.
//                Pushes into a full FIFO are dropped even when a pop happens
//                in the same cycle; pops from an empty FIFO are ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module sti_sched_fifo
    import sti_sched_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  sched_entry_t push_entry,
    input  logic         pop,
    output sched_entry_t pop_entry,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    sched_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign pop_entry = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset flushes the queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule
`default_nettype wire

// File: rtl/sti_load_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : sti_load_scheduler
//  Description : Queues parallel words and feeds them one at a time to the
//                STI_DAC serial transmitter: one load strobe per word, then
//                waits for the so_valid burst, counts its bits and flags a
//                length mismatch. The last word ends the stream (done).
//                Optional feature macro STI_SCHED_TIMEOUT_EN adds a WAIT
//                timeout and the timeout_err output.
//  Revision    : 1.0  initial release
// ============================================================================
module sti_load_scheduler
    import sti_sched_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_length,
    input  logic        req_fill,
    input  logic        req_msb,
    input  logic        req_low,
    input  logic        req_last,
    output logic        load,
    output logic [15:0] pi_data,
    output logic [1:0]  pi_length,
    output logic        pi_fill,
    output logic        pi_msb,
    output logic        pi_low,
    output logic        pi_end,
    input  logic        so_valid,
    output logic        busy,
    output logic [7:0]  word_cnt,
    output logic        len_err,
`ifdef STI_SCHED_TIMEOUT_EN
    output logic        timeout_err,
`endif
    output logic        done
);

    sched_state_t state;
    sched_state_t next_state;
    sched_entry_t push_entry;
    sched_entry_t head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         pop;
    logic [5:0]   bit_cnt;
    logic         len_chk_en;

    assign push_entry = '{last: req_last, low: req_low, msb: req_msb, fill: req_fill,
                          length: req_length, data: req_data};
    assign req_ready  = !fifo_full && (state != ST_DONE);
    assign push       = req_valid && req_ready;
    assign load       = (state == ST_LOAD);
    assign busy       = (state != ST_IDLE) && (state != ST_DONE);
    assign done       = (state == ST_DONE);

    sti_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .pop_entry  (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

`ifdef STI_SCHED_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT);

    logic [WCW-1:0] wait_cnt;
    logic           timed_out;
    logic           tmo_fire;

    // A timed-out word has no burst to measure, so its length check is skipped.
    assign len_chk_en = !timed_out;

    // wait_cnt equals the number of cycles elapsed since the load strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt    <= '0;
            timed_out   <= 1'b0;
            timeout_err <= 1'b0;
        end else if (state == ST_LOAD) begin
            wait_cnt  <= WCW'(1);
            timed_out <= 1'b0;
        end else if (tmo_fire) begin
            timed_out   <= 1'b1;
            timeout_err <= 1'b1;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign len_chk_en     = 1'b1;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state decode; the FIFO is popped on the IDLE->LOAD transition.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
`ifdef STI_SCHED_TIMEOUT_EN
        tmo_fire   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD:  next_state = ST_WAIT;
            ST_WAIT: begin
                if (so_valid) begin
                    next_state = ST_SHIFT;
                end
`ifdef STI_SCHED_TIMEOUT_EN
                else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
                    tmo_fire   = 1'b1;
                    next_state = ST_GAP;
                end
`endif
            end
            ST_SHIFT: if (!so_valid) next_state = ST_GAP;
            // pi_end is sticky and set only by the last word, so it marks the
            // word in flight as the final one.
            ST_GAP:   next_state = pi_end ? ST_DONE : ST_IDLE;
            ST_DONE:  next_state = ST_DONE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Transmitter config, bit counting and per-word completion bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pi_data   <= '0;
            pi_length <= '0;
            pi_fill   <= 1'b0;
            pi_msb    <= 1'b0;
            pi_low    <= 1'b0;
            pi_end    <= 1'b0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            len_err   <= 1'b0;
        end else begin
            if (pop) begin
                pi_data   <= head.data;
                pi_length <= head.length;
                pi_fill   <= head.fill;
                pi_msb    <= head.msb;
                pi_low    <= head.low;
                if (head.last) pi_end <= 1'b1;
            end
            case (state)
                ST_LOAD:  bit_cnt <= '0;
                ST_WAIT:  if (so_valid) bit_cnt <= bit_cnt + 6'd1;
                ST_SHIFT: if (so_valid && (bit_cnt != BIT_CNT_MAX)) bit_cnt <= bit_cnt + 6'd1;
                ST_GAP: begin
                    word_cnt <= word_cnt + 8'd1;
                    if (len_chk_en && (bit_cnt != LEN_BITS(pi_length))) len_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sti_load_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sti_load_scheduler
//  Description : Self-checking bench for sti_load_scheduler. A word-level
//                model predicts every output each cycle; directed scenarios
//                add hand-computed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sti_load_scheduler;
    import sti_sched_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
`ifdef STI_SCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_data = '0;
    logic [1:0]  req_length = '0;
    logic        req_fill = 1'b0;
    logic        req_msb = 1'b0;
    logic        req_low = 1'b0;
    logic        req_last = 1'b0;
    logic        load;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill, pi_msb, pi_low, pi_end;
    logic        so_valid = 1'b0;
    logic        busy;
    logic [7:0]  word_cnt;
    logic        len_err;
    logic        timeout_err;
    logic        done;

    int checks = 0;
    int failures = 0;
    int load_seen = 0;

    always #5 clk = ~clk;

    sti_load_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_length (req_length),
        .req_fill   (req_fill),
        .req_msb    (req_msb),
        .req_low    (req_low),
        .req_last   (req_last),
        .load       (load),
        .pi_data    (pi_data),
        .pi_length  (pi_length),
        .pi_fill    (pi_fill),
        .pi_msb     (pi_msb),
        .pi_low     (pi_low),
        .pi_end     (pi_end),
        .so_valid   (so_valid),
        .busy       (busy),
        .word_cnt   (word_cnt),
        .len_err    (len_err),
`ifdef STI_SCHED_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .done       (done)
    );
`ifndef STI_SCHED_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expired(input string name);
        checks++;
        failures++;
        $display("FAIL %s wait bound expired at %0t", name, $time);
    endtask

    // ---------------- word-level model ----------------
    sched_entry_t mq[$];        // words accepted but not yet issued
    sched_entry_t m_cur;        // word most recently issued
    bit m_free, m_done, m_end, m_len_err, m_tmo, m_load, m_ready;
    bit in_gap, started, skip_len;
    int m_words, bits, since;

    task automatic model_reset();
        mq.delete();
        m_cur = '0;
        m_free = 1; m_done = 0; m_end = 0; m_len_err = 0; m_tmo = 0;
        m_load = 0; m_ready = 1; in_gap = 0; started = 0; skip_len = 0;
        m_words = 0; bits = 0; since = 0;
    endtask

    // Advance the model by one clock using the inputs present this cycle.
    task automatic model_step();
        sched_entry_t e;
        bit accepted;
        accepted = req_valid && m_ready;
        m_load = 0;
        if (m_done) begin
            // stream finished: nothing issues until reset
        end else if (m_free) begin
            if (mq.size() > 0) begin
                m_cur = mq.pop_front();
                m_load = 1;
                m_free = 0;
                if (m_cur.last) m_end = 1;
                started = 0; in_gap = 0; skip_len = 0; bits = 0; since = 0;
            end
        end else begin
            if (in_gap) begin
                m_words = (m_words + 1) % 256;
                if (!skip_len && (bits != 8 * (int'(m_cur.length) + 1))) m_len_err = 1;
                if (m_cur.last) m_done = 1;
                else            m_free = 1;
                in_gap = 0;
            end else if (since == 0) begin
                // strobe cycle: serial activity is not counted
            end else if (!started) begin
                if (so_valid) begin
                    started = 1;
                    bits = 1;
                end else if (TMO_EN && since == TIMEOUT - 1) begin
                    m_tmo = 1;
                    skip_len = 1;
                    in_gap = 1;
                end
            end else if (so_valid) begin
                if (bits < 63) bits++;
            end else begin
                in_gap = 1;
            end
            since++;
        end
        if (accepted) begin
            e.last = req_last; e.low = req_low; e.msb = req_msb; e.fill = req_fill;
            e.length = req_length; e.data = req_data;
            mq.push_back(e);
        end
        m_ready = (mq.size() < DEPTH) && !m_done;
    endtask

    // Compare every cycle on the falling edge, then advance the model.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset) model_reset();
            chk("cyc_load", load, m_load);
            chk("cyc_req_ready", req_ready, m_ready);
            chk("cyc_busy", busy, !m_free && !m_done);
            chk("cyc_done", done, m_done);
            chk("cyc_word_cnt", word_cnt, m_words);
            chk("cyc_len_err", len_err, m_len_err);
            chk("cyc_pi_end", pi_end, m_end);
            chk("cyc_pi_data", pi_data, m_cur.data);
            chk("cyc_pi_cfg", {pi_length, pi_fill, pi_msb, pi_low},
                {m_cur.length, m_cur.fill, m_cur.msb, m_cur.low});
            if (TMO_EN) chk("cyc_timeout_err", timeout_err, m_tmo);
            if (load) load_seen++;
            if (reset) model_step();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [15:0] d, input logic [1:0] len, input logic f,
                        input logic m, input logic lo, input logic la);
        int guard = 0;
        req_data = d; req_length = len; req_fill = f; req_msb = m; req_low = lo;
        req_last = la; req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && guard < 500) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 500) expired("push_accept");
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Wait for the next load strobe, then drive an n-cycle so_valid burst.
    task automatic serve(input int n);
        int guard = 0;
        @(negedge clk);
        while (!load && guard < 500) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 500) expired("serve_load");
        @(posedge clk); #1;
        if (n > 0) begin
            so_valid = 1'b1;
            repeat (n) @(posedge clk);
            #1 so_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int guard = 0;
        @(negedge clk);
        while (!done && guard < 500) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 500) expired("wait_done");
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0; so_valid = 1'b0; req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        // 1: reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_load", load, 0);
        chk("rst_pi_end", pi_end, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_req_ready", req_ready, 1);
        @(posedge clk); #1 reset = 1'b1;

        // 2: single last word, correct 16-bit burst
        base = load_seen;
        push(16'hA5C3, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
        serve(16);
        wait_done();
        chk("t2_loads", load_seen - base, 1);
        chk("t2_pi_data", pi_data, 16'hA5C3);
        chk("t2_pi_end", pi_end, 1);
        chk("t2_word_cnt", word_cnt, 1);
        chk("t2_model_words", m_words, 1);
        chk("t2_done", done, 1);
        chk("t2_len_err", len_err, 0);
        chk("t2_ready_in_done", req_ready, 0);

        // 3: fill the FIFO during a 32-bit burst; all words issue in order
        do_reset();
        base = load_seen;
        fork
            begin
                push(16'h1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
                push(16'h2222, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
                push(16'h3333, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
                push(16'h4444, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
                push(16'h5555, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
                @(negedge clk);
                chk("t3_full_ready", req_ready, 0);
                push(16'h6666, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
            end
            begin
                serve(32); serve(8); serve(24); serve(16); serve(8); serve(16);
            end
        join
        wait_done();
        chk("t3_loads", load_seen - base, 6);
        chk("t3_word_cnt", word_cnt, 6);
        chk("t3_pi_data", pi_data, 16'h6666);
        chk("t3_len_err", len_err, 0);

        // 4: short burst flags len_err but the next word still goes out
        do_reset();
        base = load_seen;
        push(16'h1234, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
        push(16'hBEEF, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        serve(12);
        serve(8);
        wait_done();
        chk("t4_len_err", len_err, 1);
        chk("t4_model_len_err", m_len_err, 1);
        chk("t4_loads", load_seen - base, 2);
        chk("t4_word_cnt", word_cnt, 2);
        chk("t4_pi_data", pi_data, 16'hBEEF);

`ifdef STI_SCHED_TIMEOUT_EN
        // 5: no burst at all -> timeout 64 cycles after the strobe
        do_reset();
        begin
            int n;
            int guard;
            push(16'h0F0F, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            push(16'hF0F0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
            guard = 0;
            @(negedge clk);
            while (!load && guard < 100) begin guard++; @(negedge clk); end
            if (guard >= 100) expired("t5_load");
            n = 0;
            while (!timeout_err && n < 200) begin n++; @(negedge clk); end
            chk("t5_timeout_delay", n, 64);
            serve(8);
            wait_done();
            chk("t5_timeout_err", timeout_err, 1);
            chk("t5_word_cnt", word_cnt, 2);
            chk("t5_len_err", len_err, 0);
        end
`endif

        // 6: reset in the middle of a burst with three words queued
        do_reset();
        fork
            begin
                push(16'hAAAA, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
                push(16'hBBBB, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
                push(16'hCCCC, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
                push(16'hDDDD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
            end
            begin
                serve(0);
                so_valid = 1'b1;
                repeat (5) @(posedge clk);
                #3 reset = 1'b0;
                so_valid = 1'b0;
            end
        join
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_load", load, 0);
        chk("t6_req_ready", req_ready, 1);
        chk("t6_pi_data", pi_data, 0);
        @(posedge clk); #1 reset = 1'b1;
        base = load_seen;
        repeat (10) @(negedge clk);
        chk("t6_no_load_after", load_seen - base, 0);
        chk("t6_idle_busy", busy, 0);
        chk("t6_word_cnt", word_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
